line_buffer_sequencer: RTL and testbench

- Frame-level controller for the 5-line pixel line buffer in the camera/filter path.
- Reads a 512x480 8-bit grayscale frame from image memory one 32-bit word at a time and streams lines into the line buffer.
- For each output pixel, rotates the buffer and presents one window to the convolution engine over a valid/ready handshake.
- Drives the line buffer's address, vertical_count, save_data, next_matrix and size inputs.

---
 rtl/line_buffer_sequencer_if.sv | 26 ++
 rtl/line_buffer_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_line_buffer_sequencer.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/line_buffer_sequencer_if.sv
// Handshake/bus bundle between the line buffer sequencer and its neighbours.
//   mem_rd/mem_addr      : single-outstanding word read request to image memory
//   mem_rdata/mem_rvalid : read return, one per request, latency >= 1
//   mat_valid/mat_ready  : window handshake towards the convolution engine
//   pix_x/pix_y          : column/row of the window currently presented
// master = sequencer side, slave = memory/consumer side.
interface line_buffer_sequencer_if;
   logic        mem_rd;
   logic [15:0] mem_addr;
   logic [31:0] mem_rdata;
   logic        mem_rvalid;
   logic        mat_valid;
   logic        mat_ready;
   logic [8:0]  pix_x;
   logic [8:0]  pix_y;

   modport master (
      output mem_rd, mem_addr, mat_valid, pix_x, pix_y,
      input  mem_rdata, mem_rvalid, mat_ready
   );

   modport slave (
      input  mem_rd, mem_addr, mat_valid, pix_x, pix_y,
      output mem_rdata, mem_rvalid, mat_ready
   );
endinterface

// File: rtl/line_buffer_sequencer.sv
// Frame-level controller for the 5-line pixel line buffer.
// Streams image lines word by word from image memory into the line buffer,
// then rotates the buffer once per output pixel and offers each window to
// the convolution engine.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   start, size_in    : frame start pulse and window size (0=2x2, 1=3x3, 3=5x5)
//   busy, done, err   : frame status; err latches an illegal size request
//   bus (master)      : memory read bus and window handshake (see interface)
//   lb_datain, lb_address, lb_vcount, lb_save, lb_next, lb_size
//                     : line buffer control inputs
//
// state   | meaning
// S_IDLE  | waiting for start
// S_REQ   | issue one word read for line ldline, word
// S_WAIT  | wait for read data, write it into the line buffer
// S_NEXT  | line finished; keep priming or start the next output row
// S_PROC  | present windows of the current row, one per accepted handshake
// S_FLUSH | past the last image line: shift the buffer without new data
// S_DONE  | frame finished, pulse done
module line_buffer_sequencer #(
   parameter int          IMG_LINES      = 480,
   parameter int          WORDS_PER_LINE = 128,
   parameter logic [15:0] BASE_ADDR      = 16'h0000
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [1:0]              size_in,
   output logic                    busy,
   output logic                    done,
   output logic                    err,
   line_buffer_sequencer_if.master bus,
   output logic [31:0]             lb_datain,
   output logic [8:0]              lb_address,
   output logic [8:0]              lb_vcount,
   output logic                    lb_save,
   output logic                    lb_next,
   output logic [1:0]              lb_size
);
   localparam logic [6:0]  LAST_WORD = 7'(WORDS_PER_LINE - 1);
   localparam logic [8:0]  LAST_COL  = 9'(WORDS_PER_LINE * 4 - 1);
   localparam logic [8:0]  LAST_ROW  = 9'(IMG_LINES - 1);
   localparam logic [8:0]  NUM_LINES = 9'(IMG_LINES);
   localparam logic [15:0] WPL       = 16'(WORDS_PER_LINE);

   typedef enum logic [2:0] {
      S_IDLE, S_REQ, S_WAIT, S_NEXT, S_PROC, S_FLUSH, S_DONE
   } state_t;

   state_t      state;
   logic [6:0]  word;
   logic [8:0]  row;
   logic [8:0]  ldline;
   logic [8:0]  col;
   logic        mem_rd_q;
   logic [15:0] mem_addr_q;
   logic        mat_valid_q;
   logic [1:0]  la;
   logic        accept;

   // Lines that must sit in the buffer below the current row.
   assign la     = (lb_size == 2'd3) ? 2'd2 : 2'd1;
   assign accept = mat_valid_q && bus.mat_ready;

   // Rotation must happen in the very cycle the window is taken, so that the
   // next window is already aligned when mat_valid is seen again.
   assign lb_next = accept;

   assign bus.mem_rd    = mem_rd_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mat_valid = mat_valid_q;
   assign bus.pix_x     = col;
   assign bus.pix_y     = row;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
         word        <= '0;
         row         <= '0;
         ldline      <= '0;
         col         <= '0;
         mem_rd_q    <= 1'b0;
         mem_addr_q  <= '0;
         mat_valid_q <= 1'b0;
         lb_datain   <= '0;
         lb_address  <= '0;
         lb_vcount   <= '0;
         lb_save     <= 1'b0;
         lb_size     <= '0;
      end else begin
         done     <= 1'b0;
         mem_rd_q <= 1'b0;
         lb_save  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  lb_size <= size_in;
                  if (size_in == 2'd2) begin
                     err  <= 1'b1;
                     done <= 1'b1;
                  end else begin
                     err    <= 1'b0;
                     busy   <= 1'b1;
                     row    <= '0;
                     ldline <= '0;
                     word   <= '0;
                     col    <= '0;
                     state  <= S_REQ;
                  end
               end
            end
            S_REQ: begin
               mem_rd_q   <= 1'b1;
               mem_addr_q <= BASE_ADDR + {7'd0, ldline} * WPL + {9'd0, word};
               state      <= S_WAIT;
            end
            S_WAIT: begin
               if (bus.mem_rvalid) begin
                  lb_save    <= 1'b1;
                  lb_datain  <= bus.mem_rdata;
                  lb_address <= {word, 2'b00};
                  if (word == LAST_WORD) begin
                     word   <= '0;
                     ldline <= ldline + 9'd1;
                     state  <= S_NEXT;
                  end else begin
                     word  <= word + 7'd1;
                     state <= S_REQ;
                  end
               end
            end
            S_NEXT: begin
               // Row r needs lines 0..r+la resident before its first window.
               if (ldline <= {7'd0, la}) begin
                  state <= S_REQ;
               end else begin
                  col         <= '0;
                  lb_address  <= '0;
                  lb_vcount   <= row;
                  mat_valid_q <= 1'b1;
                  state       <= S_PROC;
               end
            end
            S_PROC: begin
               if (accept) begin
                  if (col == LAST_COL) begin
                     col         <= '0;
                     lb_address  <= '0;
                     row         <= row + 9'd1;
                     mat_valid_q <= 1'b0;
                     if (row == LAST_ROW) begin
                        state <= S_DONE;
                     end else if (ldline < NUM_LINES) begin
                        state <= S_REQ;
                     end else begin
                        // Shift-only write happens during the FLUSH cycle.
                        lb_save   <= 1'b1;
                        lb_datain <= '0;
                        state     <= S_FLUSH;
                     end
                  end else begin
                     col        <= col + 9'd1;
                     lb_address <= col + 9'd1;
                  end
               end
            end
            S_FLUSH: begin
               col         <= '0;
               lb_address  <= '0;
               lb_vcount   <= row;
               mat_valid_q <= 1'b1;
               state       <= S_PROC;
            end
            S_DONE: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_line_buffer_sequencer.sv
module tb_line_buffer_sequencer;
   localparam int IMG = 12;
   localparam int W   = 8;
   localparam int P   = W * 4;
   localparam int NW  = IMG * W;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  size_in;
   logic        busy, done, err;
   logic [31:0] lb_datain;
   logic [8:0]  lb_address, lb_vcount;
   logic        lb_save, lb_next;
   logic [1:0]  lb_size;

   line_buffer_sequencer_if bus_if ();

   line_buffer_sequencer #(
      .IMG_LINES      (IMG),
      .WORDS_PER_LINE (W),
      .BASE_ADDR      (16'h0000)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .size_in    (size_in),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .bus        (bus_if),
      .lb_datain  (lb_datain),
      .lb_address (lb_address),
      .lb_vcount  (lb_vcount),
      .lb_save    (lb_save),
      .lb_next    (lb_next),
      .lb_size    (lb_size)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Image memory and consumer model
   logic [31:0] img [NW];
   bit          stall_mode = 1'b0;
   bit          stray_en   = 1'b0;
   bit          pend       = 1'b0;
   int          cnt        = 0;
   logic [15:0] paddr      = '0;

   initial begin
      bus_if.mem_rvalid = 1'b0;
      bus_if.mem_rdata  = '0;
      bus_if.mat_ready  = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         bus_if.mem_rvalid = 1'b0;
         if (reset) begin
            pend = 1'b0;
         end else if (bus_if.mem_rd) begin
            pend  = 1'b1;
            cnt   = $urandom_range(1, 3);
            paddr = bus_if.mem_addr;
         end else if (pend) begin
            cnt--;
            if (cnt == 0) begin
               bus_if.mem_rvalid = 1'b1;
               bus_if.mem_rdata  = (int'(paddr) < NW) ? img[paddr] : 32'hDEADBEEF;
               pend = 1'b0;
            end
         end else if (stray_en && $urandom_range(0, 15) == 0) begin
            bus_if.mem_rvalid = 1'b1;
            bus_if.mem_rdata  = 32'hBAD0BAD0;
         end
         bus_if.mat_ready = stall_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
   end

   // Reference: reads are the frame's words in address order; saves are those
   // words followed by la shift-only writes; windows are raster order; row y
   // may start only after lines 0..min(IMG-1, y+la) are loaded.
   int       rd_cnt, sv_cnt, acc_cnt, done_cnt, la_m;
   bit       mon_en     = 1'b0;
   bit       prev_stall = 1'b0;
   logic [8:0] hold_x, hold_y;

   always @(negedge clk) begin
      if (mon_en) begin
         if (bus_if.mem_rd) begin
            chk("rd_addr", 32'(bus_if.mem_addr), rd_cnt);
            rd_cnt++;
         end
         if (lb_save) begin
            chk("save_excl_next", 32'(lb_next), 0);
            if (sv_cnt < NW) begin
               chk("save_addr", 32'(lb_address), (sv_cnt % W) * 4);
               chk("save_data", lb_datain, img[sv_cnt]);
            end else begin
               chk("flush_addr", 32'(lb_address), 0);
               chk("flush_data", lb_datain, 0);
            end
            sv_cnt++;
         end
         if (prev_stall) begin
            chk("hold_valid", 32'(bus_if.mat_valid), 1);
            chk("hold_x", 32'(bus_if.pix_x), 32'(hold_x));
            chk("hold_y", 32'(bus_if.pix_y), 32'(hold_y));
         end
         prev_stall = 1'b0;
         if (bus_if.mat_valid) begin
            chk("next_eq_ready", 32'(lb_next), 32'(bus_if.mat_ready));
            if (bus_if.mat_ready) begin
               chk("win_x", 32'(bus_if.pix_x), acc_cnt % P);
               chk("win_y", 32'(bus_if.pix_y), acc_cnt / P);
               if (acc_cnt % P == 0) begin
                  chk("row_reads", rd_cnt,
                      ((acc_cnt / P + la_m + 1 < IMG) ? (acc_cnt / P + la_m + 1) : IMG) * W);
                  chk("row_vcount", 32'(lb_vcount), acc_cnt / P);
               end
               acc_cnt++;
            end else begin
               prev_stall = 1'b1;
               hold_x     = bus_if.pix_x;
               hold_y     = bus_if.pix_y;
            end
         end else begin
            chk("next_idle", 32'(lb_next), 0);
         end
         if (done) done_cnt++;
      end
   end

   task automatic check_zero(input string tag);
      chk({tag, "_busy"},   32'(busy), 0);
      chk({tag, "_done"},   32'(done), 0);
      chk({tag, "_err"},    32'(err), 0);
      chk({tag, "_mem_rd"}, 32'(bus_if.mem_rd), 0);
      chk({tag, "_addr"},   32'(bus_if.mem_addr), 0);
      chk({tag, "_save"},   32'(lb_save), 0);
      chk({tag, "_next"},   32'(lb_next), 0);
      chk({tag, "_valid"},  32'(bus_if.mat_valid), 0);
      chk({tag, "_datain"}, lb_datain, 0);
      chk({tag, "_lbaddr"}, 32'(lb_address), 0);
      chk({tag, "_vcount"}, 32'(lb_vcount), 0);
      chk({tag, "_size"},   32'(lb_size), 0);
      chk({tag, "_pix_x"},  32'(bus_if.pix_x), 0);
      chk({tag, "_pix_y"},  32'(bus_if.pix_y), 0);
   endtask

   task automatic prep_frame(input logic [1:0] s, input bit stalls, input bit ramp);
      for (int i = 0; i < NW; i++) img[i] = ramp ? 32'(i) : $urandom;
      rd_cnt     = 0;
      sv_cnt     = 0;
      acc_cnt    = 0;
      done_cnt   = 0;
      la_m       = (s == 2'd3) ? 2 : 1;
      prev_stall = 1'b0;
      stall_mode = stalls;
      mon_en     = 1'b1;
   endtask

   task automatic start_pulse(input logic [1:0] s);
      @(posedge clk);
      #1;
      start   = 1'b1;
      size_in = s;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic run_frame(input logic [1:0] s, input bit stalls, input bit ramp, input bit poke);
      bit seen;
      int la_e;
      la_e = (s == 2'd3) ? 2 : 1;
      seen = 1'b0;
      prep_frame(s, stalls, ramp);
      start_pulse(s);
      chk("busy_rise", 32'(busy), 1);
      for (int c = 0; c < 20000 && !seen; c++) begin
         @(negedge clk);
         if (poke && c == 200) begin
            start   = 1'b1;
            size_in = 2'd2;
         end
         if (poke && c == 201) start = 1'b0;
         if (done) seen = 1'b1;
      end
      chk("done_seen", 32'(seen), 1);
      chk("busy_at_done", 32'(busy), 0);
      repeat (4) @(negedge clk);
      chk("done_once", done_cnt, 1);
      chk("reads", rd_cnt, NW);
      chk("saves", sv_cnt, NW + la_e);
      chk("windows", acc_cnt, IMG * P);
      chk("err_clear", 32'(err), 0);
      chk("lb_size", 32'(lb_size), 32'(s));
   endtask

   initial begin
      reset   = 1'b1;
      start   = 1'b0;
      size_in = 2'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_zero("rst");
      @(posedge clk);
      #1 reset = 1'b0;

      run_frame(2'd1, 1'b0, 1'b1, 1'b0);
      stray_en = 1'b1;
      run_frame(2'd3, 1'b1, 1'b0, 1'b0);
      run_frame(2'd0, 1'b1, 1'b0, 1'b1);

      // Illegal size
      prep_frame(2'd2, 1'b0, 1'b0);
      start_pulse(2'd2);
      chk("ill_done", 32'(done), 1);
      chk("ill_err", 32'(err), 1);
      chk("ill_busy", 32'(busy), 0);
      chk("ill_size", 32'(lb_size), 2);
      @(posedge clk);
      #1;
      chk("ill_done_pulse", 32'(done), 0);
      repeat (10) @(posedge clk);
      #1;
      chk("ill_reads", rd_cnt, 0);
      chk("ill_saves", sv_cnt, 0);
      chk("ill_err_held", 32'(err), 1);

      // Reset in the middle of row 3
      prep_frame(2'd1, 1'b1, 1'b0);
      start_pulse(2'd1);
      for (int c = 0; c < 20000 && acc_cnt < 3 * P + 10; c++) @(negedge clk);
      chk("midrst_reached", 32'(acc_cnt >= 3 * P + 10), 1);
      @(posedge clk);
      #1;
      mon_en     = 1'b0;
      prev_stall = 1'b0;
      reset      = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check_zero("midrst");
      @(posedge clk);
      #1 reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("midrst_nodone", 32'(done), 0);
      chk("midrst_idle", 32'(busy), 0);

      run_frame(2'd1, 1'b1, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
